// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: synchronised input, false-start rejection,
// 3-sample majority vote per bit and framing-error detection.
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] recv_data,
  output logic       vald_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(M - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(M);
  localparam logic [OS_W-1:0]  OS_DEC   = OS_W'(M + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q;
  logic             sync_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [DIV_W-1:0] div_q;
  logic [OS_W-1:0]  os_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [1:0]       samp_q;
  logic [7:0]       shreg_q;
  logic [7:0]       recv_data_q;
  logic             vald_q;
  logic             ferr_q;
  logic             busy_q;

  logic start_edge;
  logic tick;
  logic decide;
  logic bit_end;
  logic maj;

  assign start_edge = (state_q == S_IDLE) && !rx_s_q && rx_prev_q;
  // The accepting cycle restarts bit timing, so it must never also count as a tick.
  assign tick       = (div_q == DIV_LAST) && !start_edge;
  assign decide     = tick && (os_cnt_q == OS_DEC);
  assign bit_end    = tick && (os_cnt_q == OS_LAST);
  assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_HUNT;
      sync_q      <= 1'b0;
      rx_s_q      <= 1'b0;
      rx_prev_q   <= 1'b0;
      div_q       <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shreg_q     <= '0;
      recv_data_q <= '0;
      vald_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      sync_q    <= UART_RX;
      rx_s_q    <= sync_q;
      rx_prev_q <= rx_s_q;
      vald_q    <= 1'b0;
      ferr_q    <= 1'b0;

      if (start_edge) begin
        div_q    <= '0;
        os_cnt_q <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end

      if (tick && (os_cnt_q == OS_S0)) samp_q[0] <= rx_s_q;
      if (tick && (os_cnt_q == OS_S1)) samp_q[1] <= rx_s_q;

      case (state_q)
        S_HUNT: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (decide && maj) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (decide) shreg_q <= {maj, shreg_q[7:1]};
          if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          // Leave at the stop-bit centre so a following start edge is not missed.
          if (decide) begin
            if (maj) begin
              recv_data_q <= shreg_q;
              vald_q      <= 1'b1;
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_HUNT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign recv_data = recv_data_q;
  assign vald_data = vald_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at 32 CLK per bit (DIV = 2, OVERSAMPLE = 16).
module tb_uart_rx_oversample;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] recv_data;
  logic       vald_data;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int       cyc = 0;
  int       vald_cnt = 0;
  int       ferr_cnt = 0;
  int       both_cnt = 0;
  int       long_cnt = 0;
  int       busy_cyc = 0;
  int       last_t = 0;
  int       prev_t = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       vald_prev = 1'b0;
  logic       ferr_prev = 1'b0;

  uart_rx_oversample #(
    .CLK_FREQ  (3200000),
    .BAUD      (100000),
    .OVERSAMPLE(16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .UART_RX  (UART_RX),
    .recv_data(recv_data),
    .vald_data(vald_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (vald_data === 1'b1) begin
      vald_cnt  <= vald_cnt + 1;
      last_data <= recv_data;
      prev_data <= last_data;
      last_t    <= cyc;
      prev_t    <= last_t;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (vald_data === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if ((vald_data === 1'b1 && vald_prev) || (frame_err === 1'b1 && ferr_prev)) long_cnt <= long_cnt + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    vald_prev <= (vald_data === 1'b1);
    ferr_prev <= (frame_err === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame; glitch_bit/glitch_off invert the line for 2 CLK inside a bit slot.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit, input int glitch_off);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    $display("tx frame 0x%02h stop=%0b glitch_bit=%0d", d, stop, glitch_bit);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 32; c++) begin
        if (i == glitch_bit && c >= glitch_off && c < glitch_off + 2) UART_RX = ~bits[i];
        else UART_RX = bits[i];
        @(negedge CLK);
      end
    end
  endtask

  int vb, fb, bb;

  initial begin
    // Reset with idle line
    repeat (4) @(negedge CLK);
    chk("rst_recv_data", 32'(recv_data), 32'h00);
    chk("rst_vald_data", 32'(vald_data), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    chk("hunt_to_idle_busy", 32'(busy), 32'h0);

    // 1: single frame
    vb = vald_cnt; fb = ferr_cnt;
    send_frame(8'h41, 1'b1, -1, 0);
    idle(40);
    chk("t1_vald_count", 32'(vald_cnt - vb), 32'd1);
    chk("t1_data", 32'(last_data), 32'h41);
    chk("t1_recv_data_hold", 32'(recv_data), 32'h41);
    chk("t1_ferr_count", 32'(ferr_cnt - fb), 32'd0);
    chk("t1_busy", 32'(busy), 32'h0);

    // 2: back-to-back frames
    vb = vald_cnt;
    send_frame(8'h55, 1'b1, -1, 0);
    send_frame(8'hAA, 1'b1, -1, 0);
    idle(40);
    chk("t2_vald_count", 32'(vald_cnt - vb), 32'd2);
    chk("t2_first_data", 32'(prev_data), 32'h55);
    chk("t2_second_data", 32'(last_data), 32'hAA);
    chk("t2_pulse_gap", 32'(last_t - prev_t), 32'd320);

    // 3: false start
    vb = vald_cnt; fb = ferr_cnt; bb = busy_cyc;
    $display("tx glitch low 8 CLK");
    UART_RX = 1'b0;
    repeat (8) @(negedge CLK);
    idle(80);
    chk("t3_vald_count", 32'(vald_cnt - vb), 32'd0);
    chk("t3_ferr_count", 32'(ferr_cnt - fb), 32'd0);
    chk("t3_busy_len_in_range", 32'((busy_cyc - bb) >= 16 && (busy_cyc - bb) <= 22), 32'd1);
    chk("t3_busy_after", 32'(busy), 32'h0);

    // 4: majority correction on data bit 3 (slot 4), inverted around its centre sample
    vb = vald_cnt;
    send_frame(8'h0F, 1'b1, 4, 18);
    idle(40);
    chk("t4_vald_count", 32'(vald_cnt - vb), 32'd1);
    chk("t4_data", 32'(recv_data), 32'h0F);

    // 5: framing error, held-low line, then recovery
    vb = vald_cnt; fb = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, 0);
    UART_RX = 1'b0;
    repeat (200) @(negedge CLK);
    chk("t5_ferr_count", 32'(ferr_cnt - fb), 32'd1);
    chk("t5_vald_count", 32'(vald_cnt - vb), 32'd0);
    chk("t5_recv_data_kept", 32'(recv_data), 32'h0F);
    chk("t5_busy_in_break", 32'(busy), 32'h1);
    idle(40);
    chk("t5_busy_after_break", 32'(busy), 32'h0);
    send_frame(8'h7E, 1'b1, -1, 0);
    idle(40);
    chk("t5_vald_after", 32'(vald_cnt - vb), 32'd1);
    chk("t5_data_after", 32'(recv_data), 32'h7E);
    chk("t5_ferr_total", 32'(ferr_cnt - fb), 32'd1);

    // 6: reset during data bit 4 with the line low
    vb = vald_cnt; fb = ferr_cnt;
    $display("tx partial frame, reset in data bit 4");
    UART_RX = 1'b0;
    repeat (32 * 5 + 16) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_recv_data", 32'(recv_data), 32'h00);
    chk("t6_rst_vald", 32'(vald_data), 32'h0);
    chk("t6_rst_ferr", 32'(frame_err), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h1);
    RST = 1'b0;
    repeat (16) @(negedge CLK);
    chk("t6_hunt_busy", 32'(busy), 32'h1);
    chk("t6_no_vald", 32'(vald_cnt - vb), 32'd0);
    chk("t6_no_ferr", 32'(ferr_cnt - fb), 32'd0);
    idle(40);
    send_frame(8'hC3, 1'b1, -1, 0);
    idle(40);
    chk("t6_vald_count", 32'(vald_cnt - vb), 32'd1);
    chk("t6_data", 32'(recv_data), 32'hC3);
    chk("t6_ferr_count", 32'(ferr_cnt - fb), 32'd0);

    chk("strobes_exclusive", 32'(both_cnt), 32'd0);
    chk("strobes_one_cycle", 32'(long_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
Oversampling UART receiver: the stage directly upstream of the echo path's receive FIFO. It converts the asynchronous serial input into 8-bit bytes with a one-cycle valid strobe. This strobe is the FIFO write request. The block adds input synchronisation, false-start rejection, 3-sample majority voting and framing-error detection.
Format: 8N1, LSB first.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 9600, line rate in bit/s.
OVERSAMPLE, 16, ticks per bit; must be even and >= 8.
DIV (localparam), CLK_FREQ/(BAUD*OVERSAMPLE), floored; must be >= 1. Defaults give 651.

Ports:
CLK        in   1  system clock; all logic on rising edge.
RST        in   1  synchronous reset, active-high.
UART_RX    in   1  asynchronous serial line; idles high.
recv_data  out  8  last correctly framed byte.
vald_data  out  1  one-cycle strobe: recv_data updated this cycle.
frame_err  out  1  one-cycle strobe: stop bit sampled low.
busy       out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset (already decided): one clock, CLK; reset RST is synchronous and active-high.
- Reset values:
  - recv_data = 0, vald_data = 0, frame_err = 0, busy = 1 (state HUNT).
  - Synchroniser flops = 0.
  - Divider = 0, os_cnt = 0, bit_cnt = 0.
- Synchroniser: two flops; rx_s is the second flop output. All decisions use rx_s (2-cycle input latency).
- Tick generator:
  - Counts 0..DIV-1; tick = 1 when count == DIV-1, then wraps to 0.
  - Forced to 0 in the cycle a start edge is accepted.
- os_cnt: counts ticks within a bit, 0..OVERSAMPLE-1, then wraps to 0.
- Sample points: ticks M-1, M, M+1, where M = OVERSAMPLE/2 (7, 8, 9 for the default). Bit value = majority of the three samples, decided at tick M+1.
- States:
  - HUNT: wait for rx_s == 1, then go to IDLE. This prevents a line held low through reset from being taken as a start.
  - IDLE: busy = 0. When rx_s == 0 and the previous rx_s == 1 (falling edge), go to START with os_cnt = 0 and the divider cleared.
  - START:
    - Majority 1 = false start; return to IDLE at the decision tick.
    - Majority 0: continue to OVERSAMPLE-1, then go to DATA with bit_cnt = 0.
  - DATA:
    - Shift the majority value into shreg[7] at the decision tick (shift right, so LSB first).
    - At os_cnt == OVERSAMPLE-1: increment bit_cnt; after bit 7 go to STOP.
  - STOP: evaluated at the decision tick.
    - Majority 1: recv_data <= shreg and vald_data = 1 in the next cycle; go to IDLE immediately. The remaining half stop bit is not waited for, so back-to-back frames are received.
    - Majority 0: frame_err = 1 for one cycle; recv_data unchanged; go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Output hold and exclusivity:
  - recv_data holds its value until the next valid frame.
  - vald_data and frame_err are never high together.
  - Each is high for exactly one CLK per frame.
- Latency: vald_data rises 1 CLK after the stop-bit decision tick. That is about 9.5 bit periods plus 3 CLK after the start edge on the pin.
- RST mid-frame: frame abandoned, no strobe, state HUNT.
- Edges in START, DATA or STOP are ignored; only the sample points matter.
- No back-pressure: the consumer must accept each vald_data strobe. Overflow is handled by the consumer.

Test Plan:
Bench parameters: CLK_FREQ=3200000, BAUD=100000, OVERSAMPLE=16, so DIV=2 and one bit = 32 CLK.
1. Idle high, then frame 0x41 -> exactly one vald_data pulse with recv_data=0x41, frame_err=0, busy=0 after the pulse.
2. Frames 0x55 then 0xAA, zero idle gap -> two vald_data pulses 320 CLK apart, recv_data 0x55 then 0xAA.
3. Low glitch of 8 CLK on the idle line -> no strobes; busy high about 18 CLK, then returns to 0.
4. Line inverted for 2 CLK centred on tick 8 of data bit 3 in frame 0x0F -> recv_data=0x0F (majority correction).
5. Frame 0x3C with stop bit low, then line low 200 CLK, then frame 0x7E -> one frame_err pulse, no vald_data, recv_data stays at its prior value, then a vald_data pulse with 0x7E.
6. RST for 1 CLK during data bit 4 with the line low -> outputs at reset values, no strobe; line high 40 CLK, then 0xC3 received correctly.
